// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - binary32 constants and shared types
// Used by the fp32 divider and the fp32 multiplier.
package fp32_pkg;

  localparam int EXP_W     = 8;
  localparam int MANT_W    = 23;
  localparam int BIAS      = 127;
  localparam int QUOT_BITS = 26;

  localparam logic [31:0] CANON_NAN = 32'h7FC00000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    ZERO,
    NORMAL,
    INF,
    NAN
  } fp_class_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UNPACK,
    S_ITERATE,
    S_ROUND
  } div_state_t;

endpackage

// File: rtl/fp32_unpack.sv
// rtl/fp32_unpack.sv - classify a binary32 operand and expose its significand
// Ports:
//   operand    binary32 value
//   cls        ZERO / NORMAL / INF / NAN (denormals report ZERO)
//   sign       sign bit
//   biased_exp raw biased exponent
//   mant       24-bit significand with hidden bit, zero for ZERO class
module fp32_unpack
  import fp32_pkg::*;
(
  input  fp32_t                operand,
  output fp_class_t            cls,
  output logic                 sign,
  output logic [EXP_W-1:0]     biased_exp,
  output logic [MANT_W:0]      mant
);

  always_comb begin
    cls        = NORMAL;
    sign       = operand.sign;
    biased_exp = operand.exp;
    mant       = {1'b1, operand.mant};
    if (operand.exp == '0) begin
      // Denormals are flushed: treated exactly like a signed zero.
      cls  = ZERO;
      mant = '0;
    end else if (operand.exp == '1) begin
      cls = (operand.mant == '0) ? INF : NAN;
    end
  end

endmodule

// File: rtl/fp32_divide_seq.sv
// rtl/fp32_divide_seq.sv - sequential binary32 divider, one quotient bit per cycle
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   start_i             operand strobe, sampled only in IDLE
//   dividend_i          numerator a
//   divisor_i           denominator b
//   busy_o              operation in flight (UNPACK, ITERATE, ROUND)
//   done_o              one-cycle pulse, quotient valid from this cycle
//   quotient_o          a/b, round-to-nearest-even, held until next done
//   divide_by_zero_o    finite nonzero / zero, held with quotient_o
module fp32_divide_seq
  import fp32_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic        divide_by_zero_o
);

  localparam logic [4:0] ITER_LAST = 5'(QUOT_BITS - 1);

  div_state_t state_q, state_d;

  fp32_t a_q, b_q;

  fp_class_t        ca, cb;
  logic             ua_sign, ub_sign;
  logic [EXP_W-1:0] ua_exp, ub_exp;
  logic [MANT_W:0]  ua_mant, ub_mant;

  logic                   sign_q;
  logic signed [9:0]      exp_q;
  logic [QUOT_BITS-1:0]   rem_q;
  logic [MANT_W:0]        dvs_q;
  logic [QUOT_BITS-1:0]   quo_q;
  logic [4:0]             iter_q;
  logic                   special_q;
  logic [31:0]            special_val_q;
  logic                   special_dbz_q;

  logic        done_q;
  logic [31:0] quotient_q;
  logic        dbz_q;

  fp32_unpack u_unpack_a (
    .operand    (a_q),
    .cls        (ca),
    .sign       (ua_sign),
    .biased_exp (ua_exp),
    .mant       (ua_mant)
  );

  fp32_unpack u_unpack_b (
    .operand    (b_q),
    .cls        (cb),
    .sign       (ub_sign),
    .biased_exp (ub_exp),
    .mant       (ub_mant)
  );

  // Special operands: resolved once in UNPACK, replaces the arithmetic result in ROUND.
  logic        res_sign;
  logic        spec_hit;
  logic [31:0] spec_val;
  logic        spec_dbz;

  always_comb begin
    res_sign = ua_sign ^ ub_sign;
    spec_hit = 1'b1;
    spec_val = CANON_NAN;
    spec_dbz = 1'b0;
    if (ca == NAN || cb == NAN) begin
      spec_val = CANON_NAN;
    end else if ((ca == ZERO && cb == ZERO) || (ca == INF && cb == INF)) begin
      spec_val = CANON_NAN;
    end else if (ca == NORMAL && cb == ZERO) begin
      spec_val = {res_sign, 8'hFF, 23'd0};
      spec_dbz = 1'b1;
    end else if (ca == INF) begin
      spec_val = {res_sign, 8'hFF, 23'd0};
    end else if (cb == INF || ca == ZERO) begin
      spec_val = {res_sign, 31'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Restoring division step.
  logic                 rem_ge;
  logic [QUOT_BITS-1:0] rem_diff;

  always_comb begin
    rem_ge   = rem_q >= {2'b00, dvs_q};
    rem_diff = rem_q - {2'b00, dvs_q};
  end

  // Normalise, round to nearest even, then range-check the exponent.
  // The hidden bit is always 1 here, so a carry out of the 23-bit fraction
  // means the significand rounded up to 2.0: fraction wraps to 0, exponent +1.
  logic [MANT_W-1:0] frac_pre;
  logic              guard, sticky, round_up;
  logic [MANT_W:0]   frac_sum;
  logic signed [9:0] exp_adj, exp_fin;
  logic [31:0]       round_result;

  always_comb begin
    if (quo_q[QUOT_BITS-1]) begin
      frac_pre = quo_q[24:2];
      guard    = quo_q[1];
      sticky   = quo_q[0] | (rem_q != '0);
      exp_adj  = exp_q;
    end else begin
      frac_pre = quo_q[23:1];
      guard    = quo_q[0];
      sticky   = (rem_q != '0);
      exp_adj  = exp_q - 10'sd1;
    end
    round_up = guard & (sticky | frac_pre[0]);
    frac_sum = {1'b0, frac_pre} + {{MANT_W{1'b0}}, round_up};
    exp_fin  = frac_sum[MANT_W] ? exp_adj + 10'sd1 : exp_adj;
    if (exp_fin >= 10'sd255) begin
      round_result = {sign_q, 8'hFF, 23'd0};
    end else if (exp_fin <= 10'sd0) begin
      round_result = {sign_q, 31'd0};
    end else begin
      round_result = {sign_q, exp_fin[EXP_W-1:0], frac_sum[MANT_W-1:0]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_i) state_d = S_UNPACK;
      S_UNPACK:  state_d = S_ITERATE;
      S_ITERATE: if (iter_q == ITER_LAST) state_d = S_ROUND;
      S_ROUND:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_q           <= '0;
      b_q           <= '0;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      rem_q         <= '0;
      dvs_q         <= '0;
      quo_q         <= '0;
      iter_q        <= '0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      special_dbz_q <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      dbz_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            a_q <= dividend_i;
            b_q <= divisor_i;
          end
        end
        S_UNPACK: begin
          sign_q        <= res_sign;
          exp_q         <= $signed({2'b00, ua_exp}) - $signed({2'b00, ub_exp})
                           + signed'(10'(BIAS));
          rem_q         <= {2'b00, ua_mant};
          dvs_q         <= ub_mant;
          quo_q         <= '0;
          iter_q        <= '0;
          special_q     <= spec_hit;
          special_val_q <= spec_val;
          special_dbz_q <= spec_dbz;
        end
        S_ITERATE: begin
          if (rem_ge) begin
            quo_q <= {quo_q[QUOT_BITS-2:0], 1'b1};
            rem_q <= rem_diff << 1;
          end else begin
            quo_q <= {quo_q[QUOT_BITS-2:0], 1'b0};
            rem_q <= rem_q << 1;
          end
          iter_q <= iter_q + 5'd1;
        end
        S_ROUND: begin
          done_q     <= 1'b1;
          quotient_q <= special_q ? special_val_q : round_result;
          dbz_q      <= special_dbz_q;
        end
        default: ;
      endcase
    end
  end

  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = done_q;
  assign quotient_o       = quotient_q;
  assign divide_by_zero_o = dbz_q;

endmodule

// File: tb/tb_fp32_divide_seq.sv
// tb/tb_fp32_divide_seq.sv - self-checking bench for fp32_divide_seq
module tb_fp32_divide_seq;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] quotient_o;
  logic        divide_by_zero_o;

  fp32_divide_seq dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .start_i          (start_i),
    .dividend_i       (dividend_i),
    .divisor_i        (divisor_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .quotient_o       (quotient_o),
    .divide_by_zero_o (divide_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  typedef struct {
    string       name;
    logic [31:0] q;
    logic        dbz;
    int          start_edge;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        dbz;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest outstanding operation.
  always @(negedge clk_i) begin
    if (!reset_i && done_o) begin
      done_seen++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done_o=1 quotient %h, expected no done", quotient_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_quotient"}, quotient_o, e.q);
        check({e.name, "_dbz"}, {31'd0, divide_by_zero_o}, {31'd0, e.dbz});
        check({e.name, "_latency"}, 32'(cyc - e.start_edge), 32'd28);
      end
    end
  end

  task automatic drive_start(input string nm, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] q, input logic dbz);
    exp_t e;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    e.name       = nm;
    e.q          = q;
    e.dbz        = dbz;
    e.start_edge = cyc + 1;
    sb.push_back(e);
    @(negedge clk_i);
    start_i    = 1'b0;
    dividend_i = 32'hDEADBEEF;
    divisor_i  = 32'hDEADBEEF;
  endtask

  task automatic issue(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic dbz);
    @(negedge clk_i);
    drive_start(nm, a, b, q, dbz);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d outstanding results, expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic add_vec(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic dbz);
    vec_t v;
    v.name = nm; v.a = a; v.b = b; v.q = q; v.dbz = dbz;
    vecs.push_back(v);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_bad;
    int n;
    int done_before;

    add_vec("one_third",     32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0);
    add_vec("six_by_three",  32'h40C00000, 32'h40400000, 32'h40000000, 1'b0);
    add_vec("one_by_zero",   32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1);
    add_vec("neg_by_zero",   32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1);
    add_vec("zero_by_zero",  32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0);
    add_vec("overflow",      32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0);
    add_vec("underflow",     32'h00800000, 32'h40800000, 32'h00000000, 1'b0);
    add_vec("nan_operand",   32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0);
    add_vec("inf_by_inf",    32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0);
    add_vec("inf_by_zero",   32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0);
    add_vec("inf_by_two",    32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0);
    add_vec("one_by_neginf", 32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0);
    add_vec("negzero_by_1",  32'h80000000, 32'h3F800000, 32'h80000000, 1'b0);
    add_vec("denorm_num",    32'h00400000, 32'h3F800000, 32'h00000000, 1'b0);
    add_vec("denorm_den",    32'h3F800000, 32'h00000001, 32'h7F800000, 1'b1);

    reset_i    = 1'b1;
    start_i    = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_done", {31'd0, done_o}, 32'd0);
    check("reset_quotient", quotient_o, 32'd0);
    check("reset_dbz", {31'd0, divide_by_zero_o}, 32'd0);

    // 10/4 with a busy-window walk: busy for the 28 cycles up to done, low at done.
    issue("ten_by_four", 32'h41200000, 32'h40800000, 32'h40200000, 1'b0);
    busy_bad = 0;
    for (int m = 0; m <= 28; m++) begin
      if (busy_o !== (m <= 27)) busy_bad++;
      if (m < 28) @(negedge clk_i);
    end
    check("busy_window_errors", 32'(busy_bad), 32'd0);
    wait_idle("ten_by_four");

    // Back-to-back: second start lands in the done cycle of the first.
    issue("b2b_first", 32'hC1A80000, 32'h40E00000, 32'hC0400000, 1'b0);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!done_o && n < 40);
    if (!done_o) begin
      tests++;
      fails++;
      $display("FAIL b2b_wait: got no done_o, expected done within 40 cycles");
    end else begin
      drive_start("b2b_second", 32'h41200000, 32'h40800000, 32'h40200000, 1'b0);
    end
    wait_idle("b2b");

    foreach (vecs[i]) begin
      issue(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dbz);
      wait_idle(vecs[i].name);
    end

    // start_i pulse mid-ITERATE with other operands must be ignored entirely.
    issue("ignore_start", 32'h40C00000, 32'h40400000, 32'h40000000, 1'b0);
    repeat (10) @(negedge clk_i);
    dividend_i = 32'h3F800000;
    divisor_i  = 32'h00000000;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_idle("ignore_start");
    done_before = done_seen;
    repeat (35) @(negedge clk_i);
    check("ignored_start_extra_done", 32'(done_seen - done_before), 32'd0);
    check("ignored_start_busy", {31'd0, busy_o}, 32'd0);

    // Reset mid-ITERATE aborts: no done, outputs cleared on the next cycle.
    @(negedge clk_i);
    dividend_i = 32'h41200000;
    divisor_i  = 32'h40800000;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_done", {31'd0, done_o}, 32'd0);
    check("abort_quotient", quotient_o, 32'd0);
    done_before = done_seen;
    repeat (35) @(negedge clk_i);
    check("abort_no_done", 32'(done_seen - done_before), 32'd0);

    // Divider still healthy after the abort.
    issue("after_abort", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0);
    wait_idle("after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
